// File: rtl/sram_l1_req_ctrl.sv
// sram_l1_req_ctrl: single-outstanding request sequencer in front of the L1 SRAM wrapper.
// Accepts one read or write at a time, drives the active-low csb/we strobes, waits for
// data_ready on reads (with timeout), and returns one in-order response per request.
// Optional build macro: SRAM_L1_REQ_CTRL_STATS_EN adds saturating response counters.
module sram_l1_req_ctrl #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned NUM_WMASKS = 8,
  parameter int unsigned WR_HOLD    = 2,
  parameter int unsigned RD_TIMEOUT = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_is_wr,
  output logic                  rsp_err,
  output logic                  sram_csb,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [DATA_W-1:0]     sram_din,
  input  logic [DATA_W-1:0]     sram_dout,
  input  logic                  sram_data_ready
`ifdef SRAM_L1_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]           stat_rd_cnt,
  output logic [15:0]           stat_wr_cnt,
  output logic [15:0]           stat_to_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWr   = 3'd1;
  localparam logic [2:0] StRd   = 3'd2;
  localparam logic [2:0] StRsp  = 3'd3;
  localparam logic [2:0] StGap  = 3'd4;

  // Last counter value of the write hold window and of the read wait window.
  localparam logic [CNT_W-1:0] WrLast = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0] RdLast = CNT_W'(RD_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             wr_done;
  logic             rd_done;

  // Ready only while idle and out of reset, so nothing is accepted on a reset edge.
  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;
  assign wr_done   = (state_q == StWr) && (cnt_q == WrLast);
  // data_ready has priority over the timeout when both occur in the same cycle.
  assign rd_done   = (state_q == StRd) && (sram_data_ready || (cnt_q == RdLast));

  // Next-state decode for the IDLE -> WR|RD -> RSP -> GAP -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = req_we ? StWr : StRd;
      StWr:    if (wr_done) state_d = StRsp;
      StRd:    if (rd_done) state_d = StRsp;
      StRsp:   if (rsp_ready) state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register and phase counter; the counter clears whenever the state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q == StWr) || (state_q == StRd)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Strobes are registered from the next state so they change glitch-free on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_csb <= 1'b1;
      sram_we  <= 1'b1;
    end else begin
      sram_csb <= !((state_d == StWr) || (state_d == StRd));
      sram_we  <= (state_d != StWr);
    end
  end

  // Address/mask/data are captured on acceptance and held until the next acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr  <= '0;
      sram_wmask <= '0;
      sram_din   <= '0;
    end else if (accept) begin
      sram_addr  <= req_addr;
      sram_wmask <= req_wmask;
      sram_din   <= req_wdata;
    end
  end

  // Response register: loaded when a command completes, held stable until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_is_wr <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (wr_done) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= '0;
      rsp_is_wr <= 1'b1;
      rsp_err   <= 1'b0;
    end else if (rd_done) begin
      rsp_valid <= 1'b1;
      rsp_is_wr <= 1'b0;
      if (sram_data_ready) begin
        rsp_rdata <= sram_dout;
        rsp_err   <= 1'b0;
      end else begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end else if ((state_q == StRsp) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef SRAM_L1_REQ_CTRL_STATS_EN
  logic rsp_hs;
  assign rsp_hs = (state_q == StRsp) && rsp_ready;

  // Saturating per-kind response counters, bumped on the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
      stat_to_cnt <= '0;
    end else if (rsp_hs) begin
      if (rsp_is_wr) begin
        if (stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      end else if (rsp_err) begin
        if (stat_to_cnt != 16'hFFFF) stat_to_cnt <= stat_to_cnt + 16'd1;
      end else begin
        if (stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_l1_req_ctrl.sv
// tb_sram_l1_req_ctrl: directed + randomized bench with a transaction-level reference model.
`timescale 1ns/1ps
module tb_sram_l1_req_ctrl;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 64;
  localparam int NUM_WMASKS = 8;
  localparam int WR_HOLD    = 2;
  localparam int RD_TIMEOUT = 80;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int NEVER      = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_is_wr;
  logic                  rsp_err;
  logic                  sram_csb;
  logic                  sram_we;
  logic [ADDR_W-1:0]     sram_addr;
  logic [NUM_WMASKS-1:0] sram_wmask;
  logic [DATA_W-1:0]     sram_din;
  logic [DATA_W-1:0]     sram_dout;
  logic                  sram_data_ready;
`ifdef SRAM_L1_REQ_CTRL_STATS_EN
  logic [15:0]           stat_rd_cnt;
  logic [15:0]           stat_wr_cnt;
  logic [15:0]           stat_to_cnt;
`endif

  sram_l1_req_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_WMASKS(NUM_WMASKS),
    .WR_HOLD   (WR_HOLD),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_is_wr      (rsp_is_wr),
    .rsp_err        (rsp_err),
    .sram_csb       (sram_csb),
    .sram_we        (sram_we),
    .sram_addr      (sram_addr),
    .sram_wmask     (sram_wmask),
    .sram_din       (sram_din),
    .sram_dout      (sram_dout),
    .sram_data_ready(sram_data_ready)
`ifdef SRAM_L1_REQ_CTRL_STATS_EN
    ,
    .stat_rd_cnt    (stat_rd_cnt),
    .stat_wr_cnt    (stat_wr_cnt),
    .stat_to_cnt    (stat_to_cnt)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  // Wrapper memory (written through the DUT strobes) and model memory (written on acceptance).
  logic [DATA_W-1:0] wmem [DEPTH];
  logic [DATA_W-1:0] mmem [DEPTH];
  int rd_delay = 0;

  // Wrapper model: data_ready rd_delay cycles into a read; random noise outside reads.
  initial begin : wrapper_rd
    bit prev_rd;
    int wcnt;
    prev_rd = 1'b0;
    wcnt = 0;
    sram_data_ready = 1'b0;
    sram_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sram_csb === 1'b0 && sram_we === 1'b1) begin
        wcnt = prev_rd ? wcnt + 1 : 0;
        prev_rd = 1'b1;
        sram_data_ready = (wcnt == rd_delay);
        sram_dout = sram_data_ready ? wmem[sram_addr] : {$urandom, $urandom};
      end else begin
        prev_rd = 1'b0;
        sram_data_ready = 1'($urandom_range(0, 1));
        sram_dout = {$urandom, $urandom};
      end
    end
  end

  initial begin : wrapper_wr
    forever begin
      @(negedge clk);
      if (sram_csb === 1'b0 && sram_we === 1'b0) begin
        for (int b = 0; b < NUM_WMASKS; b++) begin
          if (sram_wmask[b]) wmem[sram_addr][8*b +: 8] = sram_din[8*b +: 8];
        end
      end
    end
  end

  // Reference model: one request's life as accept -> command window -> response -> gap.
  logic              m_live = 1'b0;
  logic              m_in_rst = 1'b0;
  logic              m_cmd = 1'b0;
  logic              m_rsp = 1'b0;
  logic              m_gap = 1'b0;
  logic              m_we = 1'b0;
  int                m_acc = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_din = '0;
  logic [NUM_WMASKS-1:0] m_mask = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              m_is_wr = 1'b0;
  logic              m_err = 1'b0;

  initial begin : model_cmp
    int k;
    logic idle;
    forever begin
      @(negedge clk);
      if (m_live) begin
        idle = !m_cmd && !m_rsp && !m_gap;
        chk_bit("sram_csb", sram_csb, !m_cmd);
        chk_bit("sram_we", sram_we, !(m_cmd && m_we));
        chk_bit("rsp_valid", rsp_valid, m_rsp);
        chk_bit("req_ready", req_ready, idle && !rst);
        chk_vec("sram_addr", 64'(sram_addr), 64'(m_addr));
        chk_vec("sram_wmask", 64'(sram_wmask), 64'(m_mask));
        chk_vec("sram_din", sram_din, m_din);
        if (m_rsp) begin
          chk_vec("rsp_rdata", rsp_rdata, m_rdata);
          chk_bit("rsp_is_wr", rsp_is_wr, m_is_wr);
          chk_bit("rsp_err", rsp_err, m_err);
        end
        if (m_in_rst) begin
          chk_vec("rst_rsp_rdata", rsp_rdata, 64'd0);
          chk_bit("rst_rsp_is_wr", rsp_is_wr, 1'b0);
          chk_bit("rst_rsp_err", rsp_err, 1'b0);
        end
      end
      // Advance the model to the state after the coming edge, using inputs it will sample.
      if (rst) begin
        m_live = 1'b1; m_in_rst = 1'b1;
        m_cmd = 1'b0; m_rsp = 1'b0; m_gap = 1'b0;
        m_addr = '0; m_din = '0; m_mask = '0;
      end else if (m_live) begin
        m_in_rst = 1'b0;
        k = cyc - m_acc;
        if (m_gap) begin
          m_gap = 1'b0;
        end else if (m_rsp) begin
          if (rsp_ready) begin m_rsp = 1'b0; m_gap = 1'b1; end
        end else if (m_cmd) begin
          if (m_we) begin
            if (k == WR_HOLD - 1) begin
              m_cmd = 1'b0; m_rsp = 1'b1; m_is_wr = 1'b1; m_rdata = '0; m_err = 1'b0;
            end
          end else if (sram_data_ready) begin
            m_cmd = 1'b0; m_rsp = 1'b1; m_is_wr = 1'b0; m_rdata = mmem[m_addr]; m_err = 1'b0;
          end else if (k == RD_TIMEOUT - 1) begin
            m_cmd = 1'b0; m_rsp = 1'b1; m_is_wr = 1'b0; m_rdata = '0; m_err = 1'b1;
          end
        end else if (req_valid) begin
          m_cmd = 1'b1; m_acc = cyc + 1; m_we = req_we;
          m_addr = req_addr; m_din = req_wdata; m_mask = req_wmask;
          if (req_we) begin
            for (int b = 0; b < NUM_WMASKS; b++) begin
              if (req_wmask[b]) mmem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end
          end
        end
      end
      cyc++;
    end
  end

  // Present one request and hold it until the controller takes it.
  task automatic send(input logic we, input int addr, input logic [63:0] d,
                      input logic [7:0] m, input int dly);
    int t;
    t = 0;
    rd_delay = dly;
    req_valid = 1'b1; req_we = we; req_addr = ADDR_W'(addr); req_wdata = d; req_wmask = m;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk_bit("accept_wait", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = {$urandom, $urandom};
    req_wmask = 8'($urandom);
  endtask

  // Wait for the response, hold off rsp_ready for bp cycles, then take it.
  task automatic wait_rsp(input int bp, output int csb_lo, output int lat,
                          output logic [63:0] rd, output logic err, output logic is_wr,
                          output int stray);
    csb_lo = 0; lat = 0; stray = 0;
    do begin
      @(negedge clk);
      lat++;
      if (sram_csb === 1'b0) csb_lo++;
    end while (rsp_valid !== 1'b1 && lat < 200);
    if (rsp_valid !== 1'b1) chk_bit("rsp_wait", 1'b0, 1'b1);
    rd = rsp_rdata; err = rsp_err; is_wr = rsp_is_wr;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (sram_csb === 1'b0) stray++;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lo, lat, stray, idle_n, dly;
    logic [63:0] rd;
    logic err, iw, we;
    for (int i = 0; i < DEPTH; i++) begin
      wmem[i] = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
      mmem[i] = wmem[i];
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wmask = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_bit("reset_csb", sram_csb, 1'b1);
    chk_bit("reset_we", sram_we, 1'b1);
    chk_bit("reset_rsp_valid", rsp_valid, 1'b0);
    chk_bit("reset_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // Write 48 <- 77: two strobe cycles, write response.
    send(1'b1, 48, 64'd77, 8'hFF, 0);
    wait_rsp(0, lo, lat, rd, err, iw, stray);
    chk_vec("wr_csb_cycles", 64'(lo), 64'd2);
    chk_bit("wr_is_wr", iw, 1'b1);
    chk_bit("wr_err", err, 1'b0);

    send(1'b1, 49, 64'd1, 8'hFF, 0);
    wait_rsp(0, lo, lat, rd, err, iw, stray);

    // Read 48 with data_ready on the 7th read cycle; csb rises right after.
    send(1'b0, 48, 64'd0, 8'h00, 6);
    wait_rsp(0, lo, lat, rd, err, iw, stray);
    chk_vec("rd48_data", rd, 64'd77);
    chk_bit("rd48_err", err, 1'b0);
    chk_vec("rd48_csb_cycles", 64'(lo), 64'd7);

    // Minimum read latency with data_ready in the first read cycle.
    send(1'b0, 49, 64'd0, 8'h00, 0);
    wait_rsp(0, lo, lat, rd, err, iw, stray);
    chk_vec("rd49_latency", 64'(lat), 64'd2);
    chk_vec("rd49_data", rd, 64'd1);

    // Timeout: data_ready never arrives.
    send(1'b0, 50, 64'd0, 8'h00, NEVER);
    wait_rsp(0, lo, lat, rd, err, iw, stray);
    chk_vec("to_csb_cycles", 64'(lo), 64'd80);
    chk_bit("to_err", err, 1'b1);
    chk_vec("to_rdata", rd, 64'd0);

    // Backpressure: no strobe while the response waits, then one gap cycle.
    send(1'b0, 48, 64'd0, 8'h00, 2);
    wait_rsp(5, lo, lat, rd, err, iw, stray);
    chk_vec("bp_stray_strobes", 64'(stray), 64'd0);
    chk_vec("bp_data", rd, 64'd77);
    @(negedge clk);
    chk_bit("gap_req_ready", req_ready, 1'b0);
    @(negedge clk);
    chk_bit("post_gap_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // Reset three cycles into a read: strobes drop, no response, next read is normal.
    send(1'b0, 48, 64'd0, 8'h00, NEVER);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_bit("midrst_csb", sram_csb, 1'b1);
    chk_bit("midrst_we", sram_we, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_bit("midrst_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    send(1'b0, 48, 64'd0, 8'h00, 3);
    wait_rsp(0, lo, lat, rd, err, iw, stray);
    chk_vec("after_rst_data", rd, 64'd77);
    chk_bit("after_rst_err", err, 1'b0);

    // Randomized traffic; the model checks every cycle.
    for (int n = 0; n < 40; n++) begin
      idle_n = $urandom_range(0, 2);
      repeat (idle_n) begin
        @(posedge clk);
        #1;
      end
      we = 1'($urandom);
      dly = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 9);
      send(we, 40 + $urandom_range(0, 23), {$urandom, $urandom}, 8'($urandom), dly);
      wait_rsp($urandom_range(0, 3), lo, lat, rd, err, iw, stray);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_l1_req_ctrl.md
Name: sram_l1_req_ctrl

Overview:
Request sequencer that sits directly upstream of the L1 SRAM wrapper (64-bit data, 1024+ entries, multi-cycle read with data_ready). It accepts one read or write request at a time on a valid/ready port and drives the wrapper's active-low csb/we strobes with the required hold times. It waits for data_ready on reads, with a timeout, and returns exactly one in-order response per request.

Parameters:
ADDR_W, 11, SRAM word address width
DATA_W, 64, data width
NUM_WMASKS, 8, byte-mask width (DATA_W/8)
WR_HOLD, 2, cycles csb=0/we=0 held for a write
RD_TIMEOUT, 80, max cycles waiting for sram_data_ready before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_wmask  in  NUM_WMASKS  byte mask
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_is_wr  out  1  response belongs to a write
rsp_err  out  1  read timed out
sram_csb  out  1  active-low chip select to wrapper
sram_we  out  1  active-low write enable to wrapper
sram_addr  out  ADDR_W  address to wrapper
sram_wmask  out  NUM_WMASKS  mask to wrapper
sram_din  out  DATA_W  write data to wrapper
sram_dout  in  DATA_W  wrapper read data
sram_data_ready  in  1  wrapper read-data valid

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at posedge): state=IDLE, sram_csb=1, sram_we=1, req_ready=0 during reset then 1, rsp_valid=0, rsp_rdata=0, rsp_is_wr=0, rsp_err=0, counter=0, sram_addr/wmask/din=0. Mid-operation reset aborts: the pending response is dropped, and strobes return to 1 on the same edge.
- FSM: IDLE -> WR | RD -> RSP -> GAP -> IDLE.
- IDLE: req_ready=1; on req_valid&&req_ready, register addr/wdata/wmask/we into sram_* outputs; go to WR if req_we, else RD.
- WR: sram_csb=0, sram_we=0 for exactly WR_HOLD cycles (counter 0..WR_HOLD-1); then load rsp (is_wr=1, rdata=0, err=0), go to RSP.
- RD: sram_csb=0, sram_we=1; counter increments each cycle. If sram_data_ready=1, capture sram_dout into rsp_rdata, err=0, go to RSP. Else if counter==RD_TIMEOUT-1, rdata=0, err=1, go to RSP. data_ready wins over timeout in the same cycle.
- RSP: sram_csb=1, sram_we=1; rsp_valid=1, and response fields stay stable until rsp_ready; on handshake go to GAP.
- GAP: one idle cycle with csb=1, we=1 before the next request, guaranteeing strobe deassertion between commands.
- sram_addr/wmask/din hold their values from acceptance until the next acceptance.
- No pipelining: max one outstanding request. Minimum read latency from acceptance to rsp_valid is 2 cycles (data_ready on first RD cycle).
- Counter width is $clog2(RD_TIMEOUT+1); it clears on every state entry.
- sram_data_ready outside RD is ignored.

Optional Feature:
SRAM_L1_REQ_CTRL_STATS_EN: when defined, adds outputs stat_rd_cnt, stat_wr_cnt, stat_to_cnt (16 bits each, saturating), incremented on RSP handshake for a read, a write, or an error respectively, and cleared by rst. When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst 2 cycles -> sram_csb=1, sram_we=1, rsp_valid=0, req_ready=1 on the first cycle after release.
- Write addr=48, data=77, mask=8'hFF -> sram_csb=0/sram_we=0 for exactly 2 cycles with addr 48, then rsp_valid with is_wr=1, err=0.
- Write 49<-1, then read 48 with a wrapper model asserting data_ready 6 cycles after csb falls -> rsp_rdata=77, err=0; csb rises the cycle after data_ready.
- Read with data_ready never asserted -> rsp_err=1, rdata=0 exactly 80 cycles after RD entry; csb returns to 1.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0, no new SRAM strobe; a GAP cycle occurs after the handshake.
- Reset asserted mid-RD (cycle 3) -> next edge csb=1, we=1, no response emitted; a subsequent read completes normally.
